eth_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single Ethernet MAC transmit AXI-Stream input between several packet sources (ARP engine, IP/TCP engine, test harness). Each source presents complete frames terminated by `tlast`. The arbiter grants one source for a whole frame, forwards it unmodified, and then enforces a programmable idle gap before the next grant. It sits directly in front of the MAC TX port in the `clk` domain.

---
 rtl/eth_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_eth_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - packet-level round-robin arbiter for the MAC TX stream
//
// Ports:
//   clk, sreset           : single clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tready : N_PORTS source streams, port i at [i*DATA_W +: DATA_W]
//   m_axis_tdata/tvalid/tlast/tready : single stream towards the MAC
//   grant_idx             : current or most recent granted port
//   busy                  : high while a frame is forwarded or the idle gap is running
module eth_tx_arbiter #(
   parameter int N_PORTS    = 2,
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         sreset,
   input  logic [N_PORTS*DATA_W-1:0]    s_axis_tdata,
   input  logic [N_PORTS-1:0]           s_axis_tvalid,
   input  logic [N_PORTS-1:0]           s_axis_tlast,
   output logic [N_PORTS-1:0]           s_axis_tready,
   output logic [DATA_W-1:0]            m_axis_tdata,
   output logic                         m_axis_tvalid,
   output logic                         m_axis_tlast,
   input  logic                         m_axis_tready,
   output logic [$clog2(N_PORTS)-1:0]   grant_idx,
   output logic                         busy
);

   localparam int                IDX_W    = $clog2(N_PORTS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_PORTS - 1);
   localparam logic [7:0]        GAP_LOAD = 8'(GAP_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [7:0]        gap_cnt;

   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic [IDX_W-1:0]  pick_sel;
   int                pick_pos;
   logic              frame_end;

   // Round-robin search: first requesting port at or after rr_ptr, wrapping.
   // Only tvalid is looked at, so a stalled MAC never changes who wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_pos   = 0;
      pick_sel   = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         pick_pos = int'(rr_ptr) + i;
         if (pick_pos >= N_PORTS) begin
            pick_pos = pick_pos - N_PORTS;
         end
         pick_sel = IDX_W'(pick_pos);
         if (!pick_found && s_axis_tvalid[pick_sel]) begin
            pick_found = 1'b1;
            pick_idx   = pick_sel;
         end
      end
   end

   // Zero-latency datapath: one mux level from the granted source to the MAC.
   // Outside SEND everything towards the MAC and the sources is held at 0.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      if (state == ST_SEND) begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
               m_axis_tdata     = s_axis_tdata[i*DATA_W +: DATA_W];
               m_axis_tvalid    = s_axis_tvalid[i];
               m_axis_tlast     = s_axis_tlast[i];
               s_axis_tready[i] = m_axis_tready;
            end
         end
      end
   end

   assign frame_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   always_ff @(posedge clk) begin
      if (sreset) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         grant_idx <= '0;
         gap_cnt   <= 8'd0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  grant_idx <= pick_idx;
                  state     <= ST_SEND;
                  busy      <= 1'b1;
               end
            end
            ST_SEND: begin
               // A source dropping tvalid mid-frame just holds the grant;
               // only the final handshake releases it.
               if (frame_end) begin
                  rr_ptr  <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
                  gap_cnt <= GAP_LOAD;
                  if (GAP_CYCLES == 0) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               // Counter was loaded with the gap length, so leaving on 1 gives
               // exactly GAP_CYCLES cycles in this state.
               gap_cnt <= gap_cnt - 8'd1;
               if (gap_cnt <= 8'd1) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - self-checking bench for eth_tx_arbiter
module tb_eth_tx_arbiter;

   logic        clk;
   logic        sreset;
   logic [23:0] s_tdata;
   logic [2:0]  s_tvalid;
   logic [2:0]  s_tlast;
   logic [2:0]  s_tready;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_tready;
   logic [1:0]  grant;
   logic        busy;

   logic        z_sreset;
   logic [15:0] z_tdata;
   logic [1:0]  z_tvalid;
   logic [1:0]  z_tlast;
   logic [1:0]  z_tready;
   logic [7:0]  z_mdata;
   logic        z_mvalid;
   logic        z_mlast;
   logic        z_mready;
   logic [0:0]  z_grant;
   logic        z_busy;

   int tests;
   int fails;

   eth_tx_arbiter #(.N_PORTS(3), .DATA_W(8), .GAP_CYCLES(2)) dut (
      .clk           (clk),
      .sreset        (sreset),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .grant_idx     (grant),
      .busy          (busy)
   );

   eth_tx_arbiter #(.N_PORTS(2), .DATA_W(8), .GAP_CYCLES(0)) dut_z (
      .clk           (clk),
      .sreset        (z_sreset),
      .s_axis_tdata  (z_tdata),
      .s_axis_tvalid (z_tvalid),
      .s_axis_tlast  (z_tlast),
      .s_axis_tready (z_tready),
      .m_axis_tdata  (z_mdata),
      .m_axis_tvalid (z_mvalid),
      .m_axis_tlast  (z_mlast),
      .m_axis_tready (z_mready),
      .grant_idx     (z_grant),
      .busy          (z_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        rst;
      logic [2:0]  v;
      logic [2:0]  l;
      logic [23:0] d;
      logic        rdy;
      logic        ev;
      logic        el;
      logic [7:0]  ed;
      logic [2:0]  er;
      logic [1:0]  eg;
      logic        eb;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic [2:0] v, logic [2:0] l, logic [23:0] d,
                               logic rdy, logic ev, logic el, logic [7:0] ed,
                               logic [2:0] er, logic [1:0] eg, logic eb);
      vec_t r;
      r.rst = rst; r.v = v; r.l = l; r.d = d; r.rdy = rdy;
      r.ev = ev; r.el = el; r.ed = ed; r.er = er; r.eg = eg; r.eb = eb;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      logic [23:0] base;
      logic [23:0] d1;
      int          pg;
      int          b;
      logic        rdy;
      logic [7:0]  got[$];
      int          beats[$];

      tests = 0;
      fails = 0;
      sreset = 1'b1; s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
      z_sreset = 1'b1; z_tdata = '0; z_tvalid = '0; z_tlast = '0; z_mready = 1'b1;

      // Reset state, then single source: port 0 sends 11,22,33,44.
      vecs.push_back(mk(1'b1, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));
      vecs.push_back(mk(1'b0, 3'b001, 3'b000, 24'h000011, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));
      vecs.push_back(mk(1'b0, 3'b001, 3'b000, 24'h000011, 1'b1, 1'b1, 1'b0, 8'h11, 3'b001, 2'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b001, 3'b000, 24'h000022, 1'b1, 1'b1, 1'b0, 8'h22, 3'b001, 2'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b001, 3'b000, 24'h000033, 1'b1, 1'b1, 1'b0, 8'h33, 3'b001, 2'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b001, 3'b001, 24'h000044, 1'b1, 1'b1, 1'b1, 8'h44, 3'b001, 2'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));
      vecs.push_back(mk(1'b1, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));

      // Contention: all ports hold 2-byte frames; expected grant order 0,1,2,0,1,2.
      base = 24'hC0B0A0;
      for (int k = 0; k < 6; k++) begin
         int g;
         g  = k % 3;
         pg = (k == 0) ? 0 : (k - 1) % 3;
         d1 = base;
         d1[g*8 +: 8] = base[g*8 +: 8] + 8'd1;
         vecs.push_back(mk(1'b0, 3'b111, 3'b000, base, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'(pg), 1'b0));
         vecs.push_back(mk(1'b0, 3'b111, 3'b000, base, 1'b1, 1'b1, 1'b0, base[g*8 +: 8], 3'(1 << g), 2'(g), 1'b1));
         vecs.push_back(mk(1'b0, 3'b111, 3'(1 << g), d1, 1'b1, 1'b1, 1'b1, d1[g*8 +: 8], 3'(1 << g), 2'(g), 1'b1));
         vecs.push_back(mk(1'b0, 3'b111, 3'b000, base, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'(g), 1'b1));
         vecs.push_back(mk(1'b0, 3'b111, 3'b000, base, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'(g), 1'b1));
      end
      vecs.push_back(mk(1'b1, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd2, 1'b0));

      // Source bubble: port 2 frame 31,32,33 with a 3-cycle tvalid gap; port 0 waits.
      vecs.push_back(mk(1'b0, 3'b100, 3'b000, 24'h310000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));
      vecs.push_back(mk(1'b0, 3'b101, 3'b001, 24'h31000A, 1'b1, 1'b1, 1'b0, 8'h31, 3'b100, 2'd2, 1'b1));
      vecs.push_back(mk(1'b0, 3'b001, 3'b001, 24'h32000A, 1'b1, 1'b0, 1'b0, 8'h32, 3'b100, 2'd2, 1'b1));
      vecs.push_back(mk(1'b0, 3'b001, 3'b001, 24'h32000A, 1'b1, 1'b0, 1'b0, 8'h32, 3'b100, 2'd2, 1'b1));
      vecs.push_back(mk(1'b0, 3'b001, 3'b001, 24'h32000A, 1'b1, 1'b0, 1'b0, 8'h32, 3'b100, 2'd2, 1'b1));
      vecs.push_back(mk(1'b0, 3'b101, 3'b001, 24'h32000A, 1'b1, 1'b1, 1'b0, 8'h32, 3'b100, 2'd2, 1'b1));
      vecs.push_back(mk(1'b0, 3'b101, 3'b101, 24'h33000A, 1'b1, 1'b1, 1'b1, 8'h33, 3'b100, 2'd2, 1'b1));
      vecs.push_back(mk(1'b0, 3'b001, 3'b001, 24'h00000A, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd2, 1'b1));
      vecs.push_back(mk(1'b0, 3'b001, 3'b001, 24'h00000A, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd2, 1'b1));
      vecs.push_back(mk(1'b0, 3'b001, 3'b001, 24'h00000A, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd2, 1'b0));
      vecs.push_back(mk(1'b0, 3'b001, 3'b001, 24'h00000A, 1'b1, 1'b1, 1'b1, 8'h0A, 3'b001, 2'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));

      // Reset mid-frame on byte 2 of a port 1 frame; afterwards rr_ptr is 0 so port 0 wins.
      vecs.push_back(mk(1'b0, 3'b010, 3'b000, 24'h006100, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));
      vecs.push_back(mk(1'b0, 3'b010, 3'b000, 24'h006100, 1'b1, 1'b1, 1'b0, 8'h61, 3'b010, 2'd1, 1'b1));
      vecs.push_back(mk(1'b1, 3'b010, 3'b000, 24'h006200, 1'b1, 1'b1, 1'b0, 8'h62, 3'b010, 2'd1, 1'b1));
      vecs.push_back(mk(1'b0, 3'b011, 3'b001, 24'h00610B, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));
      vecs.push_back(mk(1'b0, 3'b011, 3'b001, 24'h00610B, 1'b1, 1'b1, 1'b1, 8'h0B, 3'b001, 2'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b010, 3'b010, 24'h006100, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b010, 3'b010, 24'h006100, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'b010, 3'b010, 24'h006100, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0));
      vecs.push_back(mk(1'b0, 3'b010, 3'b010, 24'h006100, 1'b1, 1'b1, 1'b1, 8'h61, 3'b010, 2'd1, 1'b1));
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd1, 1'b1));
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd1, 1'b1));
      vecs.push_back(mk(1'b0, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 2'd1, 1'b0));

      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         sreset   = vecs[i].rst;
         s_tvalid = vecs[i].v;
         s_tlast  = vecs[i].l;
         s_tdata  = vecs[i].d;
         m_tready = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("row%0d m_tvalid", i), 32'(m_tvalid), 32'(vecs[i].ev));
         chk($sformatf("row%0d m_tlast", i),  32'(m_tlast),  32'(vecs[i].el));
         chk($sformatf("row%0d m_tdata", i),  32'(m_tdata),  32'(vecs[i].ed));
         chk($sformatf("row%0d s_tready", i), 32'(s_tready), 32'(vecs[i].er));
         chk($sformatf("row%0d grant", i),    32'(grant),    32'(vecs[i].eg));
         chk($sformatf("row%0d busy", i),     32'(busy),     32'(vecs[i].eb));
      end

      // Backpressure: port 1 sends 51..55 while the MAC ready pattern is 1,0,0,...
      @(posedge clk);
      #1;
      sreset = 1'b0; s_tvalid = 3'b010; s_tlast = 3'b000; s_tdata = 24'h005100; m_tready = 1'b1;
      @(negedge clk);
      chk("bp idle m_tvalid", 32'(m_tvalid), 32'd0);
      b = 0;
      for (int c = 0; c < 30 && b < 5; c++) begin
         @(posedge clk);
         #1;
         rdy      = (c % 3 == 0);
         s_tdata  = {8'h00, 8'h51 + 8'(b), 8'h00};
         s_tlast  = (b == 4) ? 3'b010 : 3'b000;
         s_tvalid = 3'b010;
         m_tready = rdy;
         @(negedge clk);
         chk($sformatf("bp c%0d s_tready", c), 32'(s_tready), 32'({1'b0, rdy, 1'b0}));
         chk($sformatf("bp c%0d m_tvalid", c), 32'(m_tvalid), 32'd1);
         chk($sformatf("bp c%0d m_tdata", c),  32'(m_tdata),  32'(8'h51 + 8'(b)));
         chk($sformatf("bp c%0d m_tlast", c),  32'(m_tlast),  32'(b == 4));
         chk($sformatf("bp c%0d grant", c),    32'(grant),    32'd1);
         if (m_tvalid && m_tready) got.push_back(m_tdata);
         if (rdy) b++;
      end
      chk("bp byte count", 32'(got.size()), 32'd5);
      foreach (got[i]) chk($sformatf("bp byte%0d", i), 32'(got[i]), 32'(8'h51 + 8'(i)));
      @(posedge clk);
      #1;
      s_tvalid = 3'b000; s_tlast = 3'b000; s_tdata = '0; m_tready = 1'b1;
      @(negedge clk);
      chk("bp gap1 busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("bp gap2 busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("bp idle busy", 32'(busy), 32'd0);

      // GAP_CYCLES = 0: one-beat frames on ports 0 and 1 alternate every 2 cycles.
      @(posedge clk);
      #1;
      z_sreset = 1'b0; z_tvalid = 2'b11; z_tlast = 2'b11; z_tdata = 16'hD1D0; z_mready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c % 2 == 0) begin
            chk($sformatf("g0 c%0d m_tvalid", c), 32'(z_mvalid), 32'd0);
            chk($sformatf("g0 c%0d busy", c),     32'(z_busy),   32'd0);
         end else begin
            chk($sformatf("g0 c%0d m_tvalid", c), 32'(z_mvalid), 32'd1);
            chk($sformatf("g0 c%0d m_tlast", c),  32'(z_mlast),  32'd1);
            chk($sformatf("g0 c%0d grant", c),    32'(z_grant),  32'(((c - 1) / 2) % 2));
            chk($sformatf("g0 c%0d m_tdata", c),  32'(z_mdata),  (((c - 1) / 2) % 2 == 1) ? 32'hD1 : 32'hD0);
            chk($sformatf("g0 c%0d s_tready", c), 32'(z_tready), (((c - 1) / 2) % 2 == 1) ? 32'd2 : 32'd1);
         end
         if (z_mvalid && z_mready) beats.push_back(c);
         @(posedge clk);
         #1;
      end
      chk("g0 beat count", 32'(beats.size()), 32'd5);
      for (int i = 1; i < beats.size(); i++) begin
         chk($sformatf("g0 spacing%0d", i), 32'(beats[i] - beats[i-1]), 32'd2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
